// File: rtl/float_to_fixed_seq.sv
// float_to_fixed_seq
// Multi-cycle IEEE-754 single precision to 32-bit two's-complement fixed-point
// converter.
//
// Conversion flow:
//   1. On accept, the input float is classified and the shift distance chosen.
//   2. The 24-bit mantissa is shifted by one bit per cycle, so the datapath
//      needs no barrel shifter.
//   3. The sign is applied.
//   4. The result is held until the consumer takes it.
//
// The number of fractional bits in the result is set per transaction by
// fixpointpos.

module float_to_fixed_seq #(
    parameter logic SAT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float_in,
    input  logic [4:0]  fixpointpos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fixed_out,
    output logic        ovf
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SIGN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Working registers for the conversion in flight
    logic [31:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sign_q, sign_d;
    logic        sat_q, sat_d;
    logic        ovf_pend_q, ovf_pend_d;

    // Result registers, kept stable from SIGN until the next SIGN
    logic [31:0] fixed_q, fixed_d;
    logic        ovf_q, ovf_d;

    // Fields of the incoming float and their classification
    logic               s_in;
    logic [7:0]         e_in;
    logic [22:0]        m_in;
    logic [23:0]        mant_in;
    logic signed [9:0]  sh_in;
    logic signed [9:0]  neg_sh_in;
    logic [31:0]        cls_mag;
    logic [4:0]         cls_cnt;
    logic               cls_left;
    logic               cls_sat;
    logic               cls_ovf;

    logic accept;

    assign accept = in_valid && (state_q == ST_IDLE);

    // Classify the incoming float: starting magnitude, shift direction,
    // iteration count and overflow handling for this transaction
    always_comb begin
        s_in      = float_in[31];
        e_in      = float_in[30:23];
        m_in      = float_in[22:0];
        mant_in   = {1'b1, m_in};
        sh_in     = signed'({2'b00, e_in}) + signed'({5'b00000, fixpointpos}) - 10'sd150;
        neg_sh_in = -sh_in;

        cls_mag   = {8'h00, mant_in};
        cls_cnt   = 5'd0;
        cls_left  = 1'b0;
        cls_sat   = 1'b0;
        cls_ovf   = 1'b0;

        if (e_in == 8'd0) begin
            // Zero and denormals both truncate to zero
            cls_mag = 32'd0;
        end else if (e_in == 8'hFF) begin
            // Inf/NaN: saturate, or pass the bare mantissa through when wrapping
            cls_ovf = 1'b1;
            cls_sat = SAT;
        end else if (sh_in <= -10'sd24) begin
            // Every mantissa bit falls below the binary point
            cls_mag = 32'd0;
        end else if (sh_in < 10'sd0) begin
            // Right shift; bits shifted out are dropped (truncation toward zero)
            cls_cnt = neg_sh_in[4:0];
        end else if (sh_in <= 10'sd7) begin
            // Left shift that always fits in 31 magnitude bits
            cls_cnt  = sh_in[4:0];
            cls_left = 1'b1;
        end else if (SAT) begin
            if (s_in && (m_in == 23'd0) && (sh_in == 10'sd8)) begin
                // Exactly -2^31 is representable: preload the magnitude,
                // and negation in SIGN leaves it unchanged
                cls_mag = 32'h8000_0000;
            end else begin
                cls_sat = 1'b1;
                cls_ovf = 1'b1;
            end
        end else begin
            // Wrap mode: keep shifting (at most 31 places) and keep the low word
            cls_ovf  = 1'b1;
            cls_left = 1'b1;
            cls_cnt  = (sh_in > 10'sd31) ? 5'd31 : sh_in[4:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = (cls_cnt != 5'd0) ? ST_SHIFT : ST_SIGN;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == 5'd1) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle, sign in SIGN
    always_comb begin
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        sign_d     = sign_q;
        sat_d      = sat_q;
        ovf_pend_d = ovf_pend_q;
        fixed_d    = fixed_q;
        ovf_d      = ovf_q;

        if (accept) begin
            mag_d      = cls_mag;
            cnt_d      = cls_cnt;
            left_d     = cls_left;
            sign_d     = s_in;
            sat_d      = cls_sat;
            ovf_pend_d = cls_ovf;
        end

        if (state_q == ST_SHIFT) begin
            mag_d = left_q ? {mag_q[30:0], 1'b0} : {1'b0, mag_q[31:1]};
            cnt_d = cnt_q - 5'd1;
        end

        if (state_q == ST_SIGN) begin
            if (sat_q) begin
                fixed_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                fixed_d = sign_q ? (~mag_q + 32'd1) : mag_q;
            end
            ovf_d = ovf_pend_q;
        end
    end

    // Datapath and result registers; reset discards any work in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_q      <= 32'd0;
            cnt_q      <= 5'd0;
            left_q     <= 1'b0;
            sign_q     <= 1'b0;
            sat_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            fixed_q    <= 32'd0;
            ovf_q      <= 1'b0;
        end else begin
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            left_q     <= left_d;
            sign_q     <= sign_d;
            sat_q      <= sat_d;
            ovf_pend_q <= ovf_pend_d;
            fixed_q    <= fixed_d;
            ovf_q      <= ovf_d;
        end
    end

    assign fixed_out = fixed_q;
    assign ovf       = ovf_q;

endmodule
